// File: rtl/fp_dot_seq.sv
// bf16 dot-product sequencer on one shared multiplier and one adder, plus the two arithmetic units.
// Latency: one pair per ADD_LAT+2 cycles; result ADD_LAT+2 cycles after the last pair. Backpressure: in_ready only in RUN; result held until out_ready.

// mul_fp: combinational float multiply, round-to-nearest-even, subnormals flushed to zero.
// Latency: 0 cycles.
// Backpressure: none.
module mul_fp #(
  parameter int EXP_BIT  = 8,
  parameter int MAT_BIT  = 7,
  parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1
) (
  input  logic [DATA_BIT-1:0] i_a,
  input  logic [DATA_BIT-1:0] i_b,
  output logic [DATA_BIT-1:0] o_p
);
  localparam int M  = MAT_BIT + 1;
  localparam int PW = 2 * M;
  localparam int EW = EXP_BIT + 2;
  localparam logic [EW-1:0] L_BIAS = EW'((1 << (EXP_BIT - 1)) - 1);
  localparam logic [EW-1:0] L_EMAX = EW'((1 << EXP_BIT) - 1);

  logic                       w_sign, w_up;
  logic [EXP_BIT-1:0]         w_ea, w_eb;
  logic [PW-1:0]              w_p;
  logic [PW-2:0]              w_n;
  logic [EW-1:0]              w_e;
  logic [EXP_BIT+MAT_BIT-1:0] w_mag;

  always_comb begin
    w_sign = i_a[DATA_BIT-1] ^ i_b[DATA_BIT-1];
    w_ea   = i_a[DATA_BIT-2 -: EXP_BIT];
    w_eb   = i_b[DATA_BIT-2 -: EXP_BIT];
    w_p    = {{M{1'b0}}, 1'b1, i_a[MAT_BIT-1:0]} * {{M{1'b0}}, 1'b1, i_b[MAT_BIT-1:0]};
    // Product of two [1,2) significands lies in [1,4); drop the leading one after normalising.
    w_n    = w_p[PW-1] ? w_p[PW-2:0] : {w_p[PW-3:0], 1'b0};
    w_e    = {2'b00, w_ea} + {2'b00, w_eb} - L_BIAS + {{(EW-1){1'b0}}, w_p[PW-1]};
    w_up   = w_n[MAT_BIT] & ((|w_n[MAT_BIT-1:0]) | w_n[MAT_BIT+1]);
    w_mag  = {w_e[EXP_BIT-1:0], w_n[PW-2 -: MAT_BIT]} + {{(EXP_BIT+MAT_BIT-1){1'b0}}, w_up};
    if (w_ea == '0 || w_eb == '0 || w_e[EW-1] || w_e == '0)
      o_p = {w_sign, {(DATA_BIT-1){1'b0}}};
    else if (w_e >= L_EMAX)
      o_p = {w_sign, {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
    else
      o_p = {w_sign, w_mag};
  end
endmodule

// add_fp: float add, round-to-nearest-even with exact sticky, subnormals flushed to zero.
// Latency: ENABLE_PIPELINE cycles (0 or 1).
// Backpressure: none; registered output updates every cycle.
module add_fp #(
  parameter int EXP_BIT         = 8,
  parameter int MAT_BIT         = 7,
  parameter int DATA_BIT        = EXP_BIT + MAT_BIT + 1,
  parameter int ENABLE_PIPELINE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] i_a,
  input  logic [DATA_BIT-1:0] i_b,
  output logic [DATA_BIT-1:0] o_s
);
  localparam int M  = MAT_BIT + 1;
  localparam int SW = 2 * M + 3;
  localparam int EW = EXP_BIT + 2;
  localparam logic [EW-1:0] L_EMAX = EW'((1 << EXP_BIT) - 1);

  logic                       w_swap, w_st, w_up;
  logic [DATA_BIT-1:0]        w_big, w_sml, w_res;
  logic [EXP_BIT-1:0]         w_eb, w_es, w_d;
  logic [SW-1:0]              w_mb, w_ms, w_sh, w_sum;
  logic [SW-2:0]              w_nrm;
  logic [EW-1:0]              w_lz, w_e;
  logic [EXP_BIT+MAT_BIT-1:0] w_mag;

  always_comb begin
    w_swap = i_b[DATA_BIT-2:0] > i_a[DATA_BIT-2:0];
    w_big  = w_swap ? i_b : i_a;
    w_sml  = w_swap ? i_a : i_b;
    w_eb   = w_big[DATA_BIT-2 -: EXP_BIT];
    w_es   = w_sml[DATA_BIT-2 -: EXP_BIT];
    w_mb   = {1'b0, |w_eb, w_big[MAT_BIT-1:0] & {MAT_BIT{|w_eb}}, {(M+2){1'b0}}};
    w_ms   = {1'b0, |w_es, w_sml[MAT_BIT-1:0] & {MAT_BIT{|w_es}}, {(M+2){1'b0}}};
    w_d    = w_eb - w_es;
    w_sh   = w_ms >> w_d;
    w_st   = (w_sh << w_d) != w_ms;
    w_sh   = w_sh | {{(SW-1){1'b0}}, w_st};
    w_sum  = (w_big[DATA_BIT-1] == w_sml[DATA_BIT-1]) ? w_mb + w_sh : w_mb - w_sh;
    w_lz   = '0;
    for (int i = 0; i < SW; i++)
      if (w_sum[i]) w_lz = EW'(SW - 1 - i);
    // Shifting the bits below the leading one up to the top discards the hidden bit.
    w_nrm  = w_sum[SW-2:0] << w_lz;
    w_e    = {2'b00, w_eb} + EW'(1) - w_lz;
    w_up   = w_nrm[SW-2-MAT_BIT] & ((|w_nrm[SW-3-MAT_BIT:0]) | w_nrm[SW-1-MAT_BIT]);
    w_mag  = {w_e[EXP_BIT-1:0], w_nrm[SW-2 -: MAT_BIT]} + {{(EXP_BIT+MAT_BIT-1){1'b0}}, w_up};
    if (w_sum == '0)
      w_res = '0;
    else if (w_e[EW-1] || w_e == '0)
      w_res = {w_big[DATA_BIT-1], {(DATA_BIT-1){1'b0}}};
    else if (w_e >= L_EMAX)
      w_res = {w_big[DATA_BIT-1], {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
    else
      w_res = {w_big[DATA_BIT-1], w_mag};
  end

  generate
    if (ENABLE_PIPELINE != 0) begin : g_reg
      logic [DATA_BIT-1:0] r_s;
      always_ff @(posedge clk) begin
        if (rst) r_s <= '0;
        else     r_s <= w_res;
      end
      assign o_s = r_s;
    end else begin : g_comb
      assign o_s = w_res;
    end
  endgenerate
endmodule

// fp_dot_seq: sum(A[i]*B[i]) over len pairs using one shared multiplier and adder.
// Latency: issue interval ADD_LAT+2 cycles; out_valid ADD_LAT+2 cycles after the last accepted pair.
// Backpressure: in_ready high only in RUN; out_valid/out_data held until out_ready.
module fp_dot_seq #(
  parameter int EXP_BIT  = 8,
  parameter int MAT_BIT  = 7,
  parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1,
  parameter int ADD_LAT  = 1,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_BIT-1:0] in_a,
  input  logic [DATA_BIT-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic                busy
);
  localparam int WC_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [LEN_W-1:0]    r_left;
  logic [WC_W-1:0]     r_wait;
  logic [DATA_BIT-1:0] r_acc, r_prod, r_out_data;
  logic                r_in_ready, r_out_valid, r_busy;
  logic [DATA_BIT-1:0] w_prod, w_sum;

  mul_fp #(.EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT)) u_mul (
    .i_a(in_a), .i_b(in_b), .o_p(w_prod)
  );

  add_fp #(.EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT),
           .ENABLE_PIPELINE(ADD_LAT)) u_add (
    .clk(clk), .rst(rst), .i_a(r_acc), .i_b(r_prod), .o_s(w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_left      <= '0;
      r_wait      <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_acc  <= '0;
          r_left <= len;
          r_busy <= 1'b1;
          if (len == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= '0;
          end else begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: if (in_valid) begin
          r_prod     <= w_prod;
          r_left     <= r_left - 1'b1;
          r_wait     <= WC_W'(ADD_LAT);
          r_in_ready <= 1'b0;
          r_state    <= S_WAIT;
        end
        // Adder inputs stay frozen here until its result has had ADD_LAT cycles to settle.
        S_WAIT: if (r_wait == '0) begin
          r_acc <= w_sum;
          if (r_left == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_sum;
          end else begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
          end
        end else begin
          r_wait <= r_wait - 1'b1;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
endmodule

// File: tb/tb_fp_dot_seq.sv
// Directed bench for fp_dot_seq with hand-computed bf16 results (ADD_LAT=1).
module tb_fp_dot_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int acc0 = 0;
  int acc1 = 0;
  int n = 0;
  int seen = 0;

  fp_dot_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a pair, waits (bounded) for in_ready, records the accept cycle, clocks it in.
  task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk(tag, in_ready, 1);
    last_acc = cyc;
    tick();
  endtask

  task automatic wait_done(input string tag);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 16'h0000);

    // len=3: 1*2 + 2*2 + 3*2 = 12.0
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    chk("t2_busy", busy, 1);
    send("t2_rdy0", 16'h3F80, 16'h4000);
    acc0 = last_acc;
    chk("t2_rdy_low", in_ready, 0);
    send("t2_rdy1", 16'h4000, 16'h4000);
    acc1 = last_acc;
    chk("t2_gap01", acc1 - acc0, 3);
    send("t2_rdy2", 16'h4040, 16'h4000);
    chk("t2_gap12", last_acc - acc1, 3);
    in_valid = 1'b0;
    wait_done("t2_done");
    chk("t2_latency", cyc - last_acc, 3);
    chk("t2_data", out_data, 16'h4140);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_idle_valid", out_valid, 0);
    chk("t2_idle_busy", busy, 0);

    // len=0: immediate zero result, no pair accepted
    in_valid = 1'b1; in_a = 16'h4040; in_b = 16'h4040;
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 16'h0000);
    chk("t3_no_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_idle_busy", busy, 0);

    // len=1: 3*3 = 9.0, held under backpressure
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    send("t4_rdy", 16'h4040, 16'h4040);
    in_valid = 1'b0;
    wait_done("t4_done");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 16'h4110);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle_valid", out_valid, 0);
    chk("t4_idle_busy", busy, 0);

    // len=2 with start pulses in RUN, WAIT and DONE: 1*2 + 1*2 = 4.0
    start = 1'b1; len = 8'd2;
    tick();
    len = 8'd7;
    tick();
    start = 1'b0;
    send("t5_rdy0", 16'h3F80, 16'h4000);
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send("t5_rdy1", 16'h3F80, 16'h4000);
    in_valid = 1'b0;
    wait_done("t5_done");
    chk("t5_data", out_data, 16'h4080);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_valid", out_valid, 0);
    chk("t5_no_restart", in_ready, 0);

    // rst during WAIT of a len=4 job, then a clean len=1 job
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    send("t6_rdy", 16'h4000, 16'h4000);
    in_valid = 1'b0;
    chk("t6_in_wait", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", in_ready, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("t6_no_valid", seen, 0);
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    send("t6b_rdy", 16'h3F80, 16'h4000);
    in_valid = 1'b0;
    wait_done("t6b_done");
    chk("t6b_data", out_data, 16'h4000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6b_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
